// File: rtl/jt12_op_pkg.sv
// Shared definitions for the operator register update block: word field
// positions, register group codes, slot count and the slot index helper.
package jt12_op_pkg;

  localparam int OP_SLOTS = 24;

  localparam int DT_HI  = 43;
  localparam int DT_LO  = 41;
  localparam int MUL_HI = 40;
  localparam int MUL_LO = 37;
  localparam int TL_HI  = 36;
  localparam int TL_LO  = 30;
  localparam int KS_HI  = 29;
  localparam int KS_LO  = 28;
  localparam int AR_HI  = 27;
  localparam int AR_LO  = 23;
  localparam int AM_BIT = 22;
  localparam int D1R_HI = 21;
  localparam int D1R_LO = 17;
  localparam int D2R_HI = 16;
  localparam int D2R_LO = 12;
  localparam int SL_HI  = 11;
  localparam int SL_LO  = 8;
  localparam int RR_HI  = 7;
  localparam int RR_LO  = 4;
  localparam int SSG_HI = 3;
  localparam int SSG_LO = 0;

  localparam logic [3:0] GRP_DT_MUL  = 4'h3;
  localparam logic [3:0] GRP_TL      = 4'h4;
  localparam logic [3:0] GRP_KS_AR   = 4'h5;
  localparam logic [3:0] GRP_AM_D1R  = 4'h6;
  localparam logic [3:0] GRP_D2R     = 4'h7;
  localparam logic [3:0] GRP_SL_RR   = 4'h8;
  localparam logic [3:0] GRP_SSG     = 4'h9;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } op_state_t;

  // Slot ordering: operator-major, then bank, then channel within bank.
  function automatic logic [4:0] slot_index(input logic [1:0] opi,
                                            input logic       part,
                                            input logic [1:0] ch);
    return 5'(opi) * 5'd6 + (part ? 5'd3 : 5'd0) + 5'(ch);
  endfunction

endpackage

// File: rtl/jt12_opreg_merge.sv
// Combinational field merge: replaces the fields selected by a register
// group inside a 44-bit operator word, leaving every other bit intact.
module jt12_opreg_merge
  import jt12_op_pkg::*;
(
  input  logic [43:0] word,
  input  logic [3:0]  grp,
  input  logic [7:0]  data,
  output logic [43:0] merged
);

  always_comb begin
    merged = word;
    case (grp)
      GRP_DT_MUL: begin
        merged[DT_HI:DT_LO]   = data[6:4];
        merged[MUL_HI:MUL_LO] = data[3:0];
      end
      GRP_TL: merged[TL_HI:TL_LO] = data[6:0];
      GRP_KS_AR: begin
        merged[KS_HI:KS_LO] = data[7:6];
        merged[AR_HI:AR_LO] = data[4:0];
      end
      GRP_AM_D1R: begin
        merged[AM_BIT]        = data[7];
        merged[D1R_HI:D1R_LO] = data[4:0];
      end
      GRP_D2R: merged[D2R_HI:D2R_LO] = data[4:0];
      GRP_SL_RR: begin
        merged[SL_HI:SL_LO] = data[7:4];
        merged[RR_HI:RR_LO] = data[3:0];
      end
      GRP_SSG: merged[SSG_HI:SSG_LO] = data[3:0];
      default: ;
    endcase
  end

endmodule

// File: rtl/jt12_opreg_upd.sv
// Operator parameter RAM front end: slot counter, RAM clear after reset,
// and a single pending CPU write merged into its slot as the slot passes.
module jt12_opreg_upd
  import jt12_op_pkg::*;
#(
  parameter int SLOTS = OP_SLOTS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        wr_en,
  input  logic        wr_part,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic [4:0]  ram_rd_addr,
  output logic [4:0]  ram_wr_addr,
  output logic [43:0] ram_data,
  input  logic [43:0] ram_q,
  output logic [4:0]  op_slot,
  output logic [43:0] op_word
);

  localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

  op_state_t   state, state_nx;
  logic [4:0]  slot, slot_nx;
  logic        pending, pending_nx;
  logic [7:0]  p_addr, p_data;
  logic        p_part;
  logic [4:0]  p_target;
  logic        wr_ok, accept, hit;
  logic [43:0] merged;

  jt12_opreg_merge u_merge (
    .word   (ram_q),
    .grp    (p_addr[7:4]),
    .data   (p_data),
    .merged (merged)
  );

  // Write handshake: wr_en is taken on a clk_en cycle only while busy is low;
  // anything offered while busy (or with a bad address) is dropped, not held.
  always_comb begin
    slot_nx  = (slot == SLOT_LAST) ? 5'd0 : slot + 5'd1;
    p_target = slot_index(p_addr[3:2], p_part, p_addr[1:0]);
    busy     = (state == ST_INIT) || pending;
    wr_ok    = (wr_addr[7:4] >= GRP_DT_MUL) && (wr_addr[7:4] <= GRP_SSG) &&
               (wr_addr[1:0] != 2'd3);
    accept   = wr_en && !busy && wr_ok;
    hit      = (state == ST_RUN) && pending && (slot == p_target);

    state_nx = state;
    if ((state == ST_INIT) && (slot == SLOT_LAST)) state_nx = ST_RUN;

    pending_nx = pending;
    if (hit)    pending_nx = 1'b0;
    if (accept) pending_nx = 1'b1;
  end

  // ram_q already holds the current slot's word because the read address
  // runs one slot ahead of the write address.
  always_comb begin
    ram_wr_addr = slot;
    ram_rd_addr = slot_nx;
    op_slot     = slot;
    if (state == ST_INIT) ram_data = '0;
    else if (hit)         ram_data = merged;
    else                  ram_data = ram_q;
    op_word = ram_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      slot    <= '0;
      pending <= 1'b0;
      p_addr  <= '0;
      p_data  <= '0;
      p_part  <= 1'b0;
    end else if (clk_en) begin
      state   <= state_nx;
      slot    <= slot_nx;
      pending <= pending_nx;
      if (accept) begin
        p_addr <= wr_addr;
        p_data <= wr_data;
        p_part <= wr_part;
      end
    end
  end

endmodule

// File: tb/tb_jt12_opreg_upd.sv
// Bench for jt12_opreg_upd: attached RAM model plus a per-slot field model
// that predicts every slot's word, busy and the RAM addresses each cycle.
module tb_jt12_opreg_upd;

  typedef struct {
    int dt, mul, tl, ks, ar, am, d1r, d2r, sl, rr, ssg;
  } fields_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        wr_en = 1'b0;
  logic        wr_part = 1'b0;
  logic [7:0]  wr_addr = 8'h00;
  logic [7:0]  wr_data = 8'h00;
  logic        busy;
  logic [4:0]  ram_rd_addr, ram_wr_addr, op_slot;
  logic [43:0] ram_data, op_word;
  logic [43:0] ram_q;

  logic [43:0] mem [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = 5'd0;
  logic [43:0] pre_val = 44'd0;

  int compared = 0;
  int failed = 0;

  fields_t m [24];
  fields_t zero_f;
  int      m_slot, m_grp, m_data, m_tgt;
  bit      m_init, m_pend;

  jt12_opreg_upd dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .wr_en       (wr_en),
    .wr_part     (wr_part),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .ram_rd_addr (ram_rd_addr),
    .ram_wr_addr (ram_wr_addr),
    .ram_data    (ram_data),
    .ram_q       (ram_q),
    .op_slot     (op_slot),
    .op_word     (op_word)
  );

  always #5 clk = ~clk;

  // RAM: registered read, write and read both gated by clk_en.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_val;
    else if (clk_en) begin
      mem[ram_wr_addr] <= ram_data;
      ram_q <= mem[ram_rd_addr];
    end
  end

  function automatic logic [43:0] pack(input fields_t f);
    return {3'(f.dt), 4'(f.mul), 7'(f.tl), 2'(f.ks), 5'(f.ar), 1'(f.am),
            5'(f.d1r), 5'(f.d2r), 4'(f.sl), 4'(f.rr), 4'(f.ssg)};
  endfunction

  function automatic fields_t upd(input fields_t f, input int grp, input int d);
    fields_t r = f;
    case (grp)
      3: begin r.dt = (d >> 4) & 7; r.mul = d & 15; end
      4: r.tl = d & 127;
      5: begin r.ks = (d >> 6) & 3; r.ar = d & 31; end
      6: begin r.am = (d >> 7) & 1; r.d1r = d & 31; end
      7: r.d2r = d & 31;
      8: begin r.sl = (d >> 4) & 15; r.rr = d & 15; end
      9: r.ssg = d & 15;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [43:0] obs, input logic [43:0] want);
    compared++;
    assert (obs === want) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic tick(input bit en, input bit we, input bit part, input int addr, input int data);
    bit busy_m, hit, acc;
    int grp, ch, opi;
    logic [43:0] exp_w;
    clk_en = en; wr_en = we; wr_part = part;
    wr_addr = 8'(addr); wr_data = 8'(data);
    busy_m = m_init || m_pend;
    hit = !m_init && m_pend && (m_tgt == m_slot);
    if (m_init)   exp_w = '0;
    else if (hit) exp_w = pack(upd(m[m_slot], m_grp, m_data));
    else          exp_w = pack(m[m_slot]);
    chk("busy", 44'(busy), 44'(busy_m));
    chk("ram_wr_addr", 44'(ram_wr_addr), 44'(m_slot));
    chk("ram_rd_addr", 44'(ram_rd_addr), 44'((m_slot + 1) % 24));
    chk("op_slot", 44'(op_slot), 44'(m_slot));
    chk("ram_data", ram_data, exp_w);
    chk("op_word", op_word, exp_w);
    grp = (addr >> 4) & 15; ch = addr & 3; opi = (addr >> 2) & 3;
    acc = en && we && !busy_m && grp >= 3 && grp <= 9 && ch != 3;
    @(posedge clk); #1;
    if (en) begin
      if (m_init) begin
        m[m_slot] = zero_f;
        if (m_slot == 23) m_init = 0;
      end else if (hit) begin
        m[m_slot] = upd(m[m_slot], m_grp, m_data);
        m_pend = 0;
      end
      if (acc) begin
        m_pend = 1; m_grp = grp; m_data = data & 255;
        m_tgt = opi * 6 + int'(part) * 3 + ch;
      end
      m_slot = (m_slot + 1) % 24;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input bit en);
    rst_n = 1'b0; clk_en = en; wr_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_init = 1; m_slot = 0; m_pend = 0;
    chk("rst_busy", 44'(busy), 44'd1);
    chk("rst_rd_addr", 44'(ram_rd_addr), 44'd1);
    chk("rst_wr_addr", 44'(ram_wr_addr), 44'd0);
    chk("rst_ram_data", ram_data, 44'd0);
  endtask

  task automatic check_ram(input string tag);
    for (int s = 0; s < 24; s++) chk($sformatf("%s[%0d]", tag, s), mem[s], pack(m[s]));
  endtask

  initial begin
    zero_f = '{default: 0};
    for (int s = 0; s < 24; s++) m[s] = zero_f;
    m_init = 1; m_slot = 0; m_pend = 0; m_tgt = 0; m_grp = 0; m_data = 0;

    // Fill the RAM with garbage so the clear pass has something to wipe.
    for (int s = 0; s < 32; s++) begin
      pre_we = 1'b1; pre_addr = 5'(s);
      pre_val = 44'({$urandom(), $urandom()});
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    do_reset(1'b1);
    idle(24);
    chk("init_done_busy", 44'(busy), 44'd0);
    check_ram("init_zero");

    tick(1, 1, 0, 'h40, 'h7F);
    idle(30);
    chk("tl_slot0", mem[0], 44'({7'h7F, 30'd0}));
    check_ram("tl");

    tick(1, 1, 1, 'h3D, 'h35);
    idle(48);
    chk("dt_mul_slot22", mem[22], {3'd3, 4'd5, 37'd0});
    check_ram("dt_mul");

    tick(1, 1, 0, 'h33, 'h55);
    tick(1, 1, 1, 'hA0, 'hFF);
    idle(48);
    check_ram("dropped");

    tick(1, 1, 0, 'h52, 'hC5);
    tick(1, 1, 0, 'h90, 'h0F);
    idle(30);
    chk("ks_ar_slot2", mem[2], 44'({2'd3, 5'd5, 23'd0}));
    check_ram("busy_drop");

    tick(1, 1, 1, 'h64, 'hBF);
    for (int i = 0; i < 100; i++) tick(i % 2 == 1, 0, 0, 0, 0);
    chk("am_d1r_slot9", mem[9], 44'({1'b1, 5'h1F, 17'd0}));
    check_ram("toggle");

    for (int i = 0; i < 400; i++) begin
      int g, o, c;
      g = $urandom_range(2, 10); o = $urandom_range(0, 3); c = $urandom_range(0, 3);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
           (g << 4) | (o << 2) | c, $urandom_range(0, 255));
    end
    idle(60);
    check_ram("random");

    tick(1, 1, 1, 'h8A, 'hFF);
    idle(3);
    chk("pending_busy", 44'(busy), 44'd1);
    do_reset(1'b0);
    idle(24);
    chk("reinit_slot17", mem[17], 44'd0);
    check_ram("reinit");
    idle(30);
    check_ram("after_reinit");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
